blocb_y_capture: RTL and testbench

- Downstream stage of blocb: consumes blocb's single-bit output y.
- Samples y under a qualifier, deserializes WIDTH samples into a word and offers it on a valid/ready handshake.
- Also keeps a saturating count of rising edges on y and a sticky overflow flag for dropped words.
- Lets the lab bench check blocking/non-blocking results as words instead of by waveform inspection.

---
 rtl/blocb_y_capture_if.sv | 21 ++
 rtl/blocb_y_capture.sv | 150 +++++++++++++++
 tb/tb_blocb_y_capture.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/blocb_y_capture_if.sv
// Word handshake between blocb_y_capture and whatever consumes its deserialized words.
// The capture block drives the master side; the consumer sits on the slave side.
interface blocb_y_capture_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/blocb_y_capture.sv
// Capture stage for blocb's y output: packs qualified samples into WIDTH-bit words, counts rising edges.
// Define BLOCB_CAPTURE_SYNC_EN to put a 2-flop synchronizer (with matching sample_en delay) in front.
module blocb_y_capture #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               y_in,
    input  logic               sample_en,
    blocb_y_capture_if.master  cap,
    output logic [CNT_W-1:0]   edge_count,
    output logic               overflow
);
    localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic             w_yPre;
    logic             w_enPre;
    logic             r_yQ;
    logic             r_enQ;
    logic             r_yPrev;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_outData;
    logic [WIDTH-1:0] w_word;
    logic [BCW-1:0]   r_bitCnt;
    logic [CNT_W-1:0] r_edgeCnt;
    logic             r_overflow;
    logic             w_rise;
    logic             w_done;
    logic             w_load;
    logic             w_drop;

`ifdef BLOCB_CAPTURE_SYNC_EN
    logic [1:0] r_ySync;
    logic [1:0] r_enSync;

    // sample_en rides through the same number of flops so each bit keeps its qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ySync  <= '0;
            r_enSync <= '0;
        end else begin
            r_ySync  <= {r_ySync[0], y_in};
            r_enSync <= {r_enSync[0], sample_en};
        end
    end

    assign w_yPre  = r_ySync[1];
    assign w_enPre = r_enSync[1];
`else
    assign w_yPre  = y_in;
    assign w_enPre = sample_en;
`endif

    // The input stage keeps loading during clr so no sample is lost across a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yQ  <= 1'b0;
            r_enQ <= 1'b0;
        end else begin
            r_yQ  <= w_yPre;
            r_enQ <= w_enPre;
        end
    end

    assign w_rise = r_yQ & ~r_yPrev;
    assign w_done = r_enQ && (r_bitCnt == BCW'(WIDTH - 1));
    assign w_word = {r_shreg[WIDTH-2:0], r_yQ};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        if (clr) begin
            w_stateNext = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_done) begin
                        w_load      = 1'b1;
                        w_stateNext = S_FULL;
                    end
                end
                S_FULL: begin
                    if (cap.out_ready) begin
                        if (w_done) begin
                            w_load = 1'b1;
                        end else begin
                            w_stateNext = S_EMPTY;
                        end
                    end else if (w_done) begin
                        w_drop = 1'b1;
                    end
                end
                default: w_stateNext = S_EMPTY;
            endcase
        end
    end

    // out_data is deliberately left alone by clr; out_valid dropping is what invalidates it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yPrev    <= 1'b0;
            r_shreg    <= '0;
            r_bitCnt   <= '0;
            r_edgeCnt  <= '0;
            r_overflow <= 1'b0;
            r_outData  <= '0;
        end else if (clr) begin
            r_yPrev    <= 1'b0;
            r_shreg    <= '0;
            r_bitCnt   <= '0;
            r_edgeCnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_yPrev <= r_yQ;
            if (w_rise && (r_edgeCnt != {CNT_W{1'b1}})) begin
                r_edgeCnt <= r_edgeCnt + 1'b1;
            end
            if (r_enQ) begin
                r_shreg  <= w_word;
                r_bitCnt <= w_done ? '0 : r_bitCnt + 1'b1;
            end
            if (w_load) begin
                r_outData <= w_word;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cap.out_data  = r_outData;
    assign cap.out_valid = (r_state == S_FULL);
    assign edge_count    = r_edgeCnt;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_blocb_y_capture.sv
// Bench for blocb_y_capture (WIDTH=4, CNT_W=4): directed steps then random traffic against a word-level model.
// Honours BLOCB_CAPTURE_SYNC_EN by lengthening the model's input delay.
module tb_blocb_y_capture;
    localparam int WIDTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BLOCB_CAPTURE_SYNC_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             y_in;
    logic             sample_en;
    logic [CNT_W-1:0] edge_count;
    logic             overflow;

    blocb_y_capture_if #(.WIDTH(WIDTH)) capIf ();

    blocb_y_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .y_in       (y_in),
        .sample_en  (sample_en),
        .cap        (capIf.master),
        .edge_count (edge_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compCount = 0;
    int failCount = 0;

    // Reference model: inputs reach the capture logic DEPTH edges after being applied
    logic pipeY [0:2];
    logic pipeE [0:2];
    int   mAcc;
    int   mBits;
    int   mCount;
    logic mYPrev;
    logic mValid;
    logic mOvf;
    logic [WIDTH-1:0] mData;

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            pipeY[i] = 1'b0;
            pipeE[i] = 1'b0;
        end
        mAcc = 0; mBits = 0; mCount = 0;
        mYPrev = 1'b0; mValid = 1'b0; mOvf = 1'b0; mData = '0;
    endtask

    task automatic modelEdge(input logic y, input logic en, input logic rdy, input logic c);
        logic yq;
        logic enq;
        logic done;
        logic [WIDTH-1:0] word;
        yq   = pipeY[DEPTH-1];
        enq  = pipeE[DEPTH-1];
        done = enq && (mBits == WIDTH - 1);
        word = WIDTH'((mAcc * 2) + int'(yq));
        if (c) begin
            mAcc = 0; mBits = 0; mCount = 0;
            mOvf = 1'b0; mValid = 1'b0; mYPrev = 1'b0;
        end else begin
            if (yq && !mYPrev && mCount < CNT_MAX) mCount++;
            mYPrev = yq;
            if (enq) begin
                if (done) begin
                    mAcc = 0; mBits = 0;
                end else begin
                    mAcc = (mAcc * 2) + int'(yq); mBits++;
                end
            end
            if (done) begin
                if (!mValid || rdy) begin
                    mData = word; mValid = 1'b1;
                end else begin
                    mOvf = 1'b1;
                end
            end else if (mValid && rdy) begin
                mValid = 1'b0;
            end
        end
        for (int i = DEPTH - 1; i > 0; i--) begin
            pipeY[i] = pipeY[i-1];
            pipeE[i] = pipeE[i-1];
        end
        pipeY[0] = y;
        pipeE[0] = en;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compCount++;
        assert (got === exp) else begin
            failCount++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".valid"},    32'(capIf.out_valid), 32'(mValid));
        checkOne({tag, ".data"},     32'(capIf.out_data),  32'(mData));
        checkOne({tag, ".edgeCnt"},  32'(edge_count),      32'(mCount));
        checkOne({tag, ".overflow"}, 32'(overflow),        32'(mOvf));
    endtask

    task automatic applyStimulus(input logic y, input logic en, input logic rdy, input logic c,
                                 input string tag);
        y_in = y; sample_en = en; capIf.out_ready = rdy; clr = c;
        @(posedge clk);
        modelEdge(y, en, rdy, c);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] w, input logic rdy, input string tag);
        logic [WIDTH-1:0] tmp;
        tmp = w;
        for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(tmp[i], 1'b1, rdy, 1'b0, tag);
    endtask

    task automatic waitWord(input logic [WIDTH-1:0] exp, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, tag);
            seen = capIf.out_valid;
        end
        checkOne({tag, ".arrived"}, 32'(capIf.out_valid), 32'(1));
        checkOne({tag, ".word"},    32'(capIf.out_data),  32'(exp));
    endtask

    initial begin
        modelReset();
        rst_n = 1'b0; clr = 1'b0; y_in = 1'b1; sample_en = 1'b0; capIf.out_ready = 1'b0;
        #12;
        checkOne("reset.valid", 32'(capIf.out_valid), 32'(0));
        checkOne("reset.edgeCnt", 32'(edge_count), 32'(0));
        rst_n = 1'b1;

        // y held high across reset release is one edge
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "holdHigh");
        checkOne("holdHigh.edgeOnce", 32'(edge_count), 32'(1));
        checkOne("holdHigh.noOvf", 32'(overflow), 32'(0));

        sendWord(4'b1011, 1'b1, "word1");
        waitWord(4'b1011, "word1");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "word1.consumed");

        sendWord(4'b1100, 1'b0, "stallA");
        sendWord(4'b0101, 1'b0, "stallB");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "stallWait");
        checkOne("stall.keepFirst", 32'(capIf.out_data), 32'(4'b1100));
        checkOne("stall.overflow", 32'(overflow), 32'(1));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "stall.drain");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "stall.empty");

        // Partial word then an asynchronous reset between edges
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "partial");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "partial");
        #2;
        rst_n = 1'b0; y_in = 1'b0; sample_en = 1'b0;
        #1;
        checkOne("asyncRst.valid", 32'(capIf.out_valid), 32'(0));
        checkOne("asyncRst.overflow", 32'(overflow), 32'(0));
        checkOne("asyncRst.edgeCnt", 32'(edge_count), 32'(0));
        modelReset();
        rst_n = 1'b1;
        sendWord(4'b0110, 1'b1, "afterRst");
        waitWord(4'b0110, "afterRst");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "clrA");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "toggle");
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "toggle");
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "toggleWait");
        checkOne("toggle.ten", 32'(edge_count), 32'(10));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "saturate");
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "saturate");
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "saturateWait");
        checkOne("saturate.max", 32'(edge_count), 32'(CNT_MAX));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "clrB");
        checkOne("clrB.edgeCnt", 32'(edge_count), 32'(0));

        sendWord(4'b0111, 1'b1, "word7");
        waitWord(4'b0111, "word7");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end
endmodule
